cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 The block SHALL have parameter N_FU, default 4, giving the number of functional-unit result ports (2..8).
REQ-002 The block SHALL have parameter DEPTH, default 2, giving result-queue entries per FU (fixed at 2 for this revision).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 fu_valid  input  N_FU  bit i: FU i presents a result this cycle.
REQ-006 fu_tag  input  8*N_FU  bits [8i+7:8i]: RS tag {FU[7:5], entry[4:0]} of FU i's result.
REQ-007 fu_data  input  32*N_FU  bits [32i+31:32i]: result value of FU i.
REQ-008 fu_ready  output  N_FU  bit i: FU i's queue can accept a result this cycle.
REQ-009 cdb_rs_num  output  8  broadcast tag; 0 means no broadcast this cycle.
REQ-010 cdb_data  output  32  broadcast value, valid when cdb_rs_num != 0.
REQ-011 pending  output  1  at least one queued result not yet broadcast.
REQ-012 bcast_cnt  output  16  number of broadcasts since reset.

Function
REQ-013 The block SHALL keep one FIFO of DEPTH entries per FU, each entry {tag[7:0], data[31:0]}, with 2-bit count, head and tail pointers.
REQ-014 fu_ready[i] SHALL equal (count_i != DEPTH) and not rst; it SHALL be combinational from registered state only, with no pop-through credit.
REQ-015 Push to FIFO i SHALL occur on an edge where fu_valid[i] && fu_ready[i] && fu_tag[i] != 0.
REQ-016 A valid result with tag 0 SHALL be discarded without enqueue; fu_ready is unaffected.
REQ-017 On each edge, the arbiter SHALL select one non-empty FIFO by round-robin starting at rr_ptr, pop its head, and register it into cdb_rs_num/cdb_data.
REQ-018 After a grant to FU g, rr_ptr SHALL become (g+1) mod N_FU; with no grant, rr_ptr SHALL hold.
REQ-019 If all FIFOs are empty at an edge, cdb_rs_num and cdb_data SHALL both be registered to 0.
REQ-020 Each broadcast SHALL last exactly one cycle; a tag SHALL never be broadcast twice from one push.
REQ-021 Latency: a result pushed at edge k SHALL appear on the CDB no earlier than the cycle following edge k+1; a lone result on an idle arbiter SHALL appear exactly then.
REQ-022 Simultaneous push and pop on the same FIFO SHALL leave count unchanged, with FIFO order preserved; head/tail SHALL wrap modulo DEPTH.
REQ-023 Results from one FU SHALL be broadcast in push order; no ordering is guaranteed across FUs.
REQ-024 pending SHALL be the OR over (count_i != 0), taken from registered state.
REQ-025 bcast_cnt SHALL increment by 1 on every edge that registers a nonzero cdb_rs_num, wrapping 0xFFFF -> 0x0000.
REQ-026 Worst-case wait for a non-empty FIFO SHALL be N_FU-1 grants (starvation-free).

Reset
REQ-027 With rst high at an edge, all counts, head/tail pointers, rr_ptr, cdb_rs_num, cdb_data and bcast_cnt SHALL be set to 0.
REQ-028 While rst is high, fu_ready SHALL be 0 and input pushes SHALL be ignored.
REQ-029 Reset asserted mid-operation SHALL discard all queued results; no queued result SHALL be broadcast after reset.

Verification
REQ-030 Single result: idle; FU1 pushes tag 0x21, data 0xDEADBEEF at edge 0 -> cdb_rs_num=0x21, cdb_data=0xDEADBEEF for exactly the cycle after edge 1, then 0; bcast_cnt=1.
REQ-031 Contention: FU0..FU3 push tags 0x01,0x21,0x41,0x61 at the same edge -> broadcasts on 4 consecutive cycles in order 0x01,0x21,0x41,0x61; rr_ptr ends at 0.
REQ-032 Back-pressure: FU2 holds valid with a new tag every cycle while FU0 is also continuously pushing -> fu_ready[2] drops after 2 unpopped pushes; no tag is lost or duplicated; FU2 tags are broadcast in push order.
REQ-033 Tag zero: FU3 valid with tag 0x00 -> nothing enqueued, pending stays 0, CDB stays 0.
REQ-034 Reset mid-flight: 3 results queued, rst held high for 1 edge -> cdb_rs_num=0, pending=0, bcast_cnt=0, fu_ready=0 during rst and all 1s after; no stale tag appears afterwards.
REQ-035 Counter wrap: 65536 broadcasts -> bcast_cnt returns to 0x0000.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-FU result FIFOs, round-robin grant, one broadcast per cycle.
// Latency: a lone result pushed at edge k is broadcast during the cycle after edge k+1.
// Backpressure: fu_ready drops when an FU's FIFO is full, from registered state only.
module cdb_arbiter #(
    parameter int N_FU  = 4,
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_FU-1:0]      fu_valid,
    input  logic [8*N_FU-1:0]    fu_tag,
    input  logic [32*N_FU-1:0]   fu_data,
    output logic [N_FU-1:0]      fu_ready,
    output logic [7:0]           cdb_rs_num,
    output logic [31:0]          cdb_data,
    output logic                 pending,
    output logic [15:0]          bcast_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int RR_W  = $clog2(N_FU);
    localparam logic [1:0] FULL = 2'(DEPTH);

    typedef struct packed {
        logic [7:0]  tag;
        logic [31:0] data;
    } entry_t;

    entry_t           mem_q   [N_FU][DEPTH];
    logic [1:0]       count_q [N_FU];
    logic [1:0]       count_d [N_FU];
    logic [PTR_W-1:0] head_q  [N_FU];
    logic [PTR_W-1:0] head_d  [N_FU];
    logic [PTR_W-1:0] tail_q  [N_FU];
    logic [PTR_W-1:0] tail_d  [N_FU];
    logic [RR_W-1:0]  rr_q, rr_d;
    logic [7:0]       cdb_rs_num_q, cdb_rs_num_d;
    logic [31:0]      cdb_data_q, cdb_data_d;
    logic [15:0]      bcast_cnt_q, bcast_cnt_d;

    logic [N_FU-1:0]  push;
    logic [N_FU-1:0]  pop;
    logic             gnt_vld;
    logic [RR_W-1:0]  gnt_idx;
    entry_t           gnt_entry;

    // Tag 0 means "no result", so such pushes are dropped without touching the FIFO.
    always_comb begin
        fu_ready = '0;
        push     = '0;
        pending  = 1'b0;
        for (int i = 0; i < N_FU; i++) begin
            fu_ready[i] = (count_q[i] != FULL) && !rst;
            push[i]     = fu_valid[i] && fu_ready[i] && (fu_tag[8*i +: 8] != 8'h00);
            pending     = pending | (count_q[i] != 2'd0);
        end
    end

    // Round-robin: pick the non-empty FIFO closest to rr_q in rotational order.
    always_comb begin
        int best_off;
        int off;
        best_off  = N_FU;
        off       = 0;
        gnt_vld   = 1'b0;
        gnt_idx   = '0;
        gnt_entry = '0;
        for (int i = 0; i < N_FU; i++) begin
            off = (i - int'(rr_q) + N_FU) % N_FU;
            if ((count_q[i] != 2'd0) && (off < best_off)) begin
                best_off  = off;
                gnt_vld   = 1'b1;
                gnt_idx   = RR_W'(i);
                gnt_entry = mem_q[i][head_q[i]];
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < N_FU; i++) begin
            pop[i]     = gnt_vld && (gnt_idx == RR_W'(i));
            count_d[i] = count_q[i] + {1'b0, push[i]} - {1'b0, pop[i]};
            head_d[i]  = head_q[i];
            tail_d[i]  = tail_q[i];
            if (pop[i]) begin
                head_d[i] = (head_q[i] == PTR_W'(DEPTH-1)) ? '0 : head_q[i] + 1'b1;
            end
            if (push[i]) begin
                tail_d[i] = (tail_q[i] == PTR_W'(DEPTH-1)) ? '0 : tail_q[i] + 1'b1;
            end
        end

        rr_d         = rr_q;
        cdb_rs_num_d = 8'h00;
        cdb_data_d   = 32'h0;
        bcast_cnt_d  = bcast_cnt_q;
        if (gnt_vld) begin
            rr_d         = (gnt_idx == RR_W'(N_FU-1)) ? '0 : gnt_idx + 1'b1;
            cdb_rs_num_d = gnt_entry.tag;
            cdb_data_d   = gnt_entry.data;
            bcast_cnt_d  = bcast_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_FU; i++) begin
                count_q[i] <= '0;
                head_q[i]  <= '0;
                tail_q[i]  <= '0;
            end
            rr_q         <= '0;
            cdb_rs_num_q <= '0;
            cdb_data_q   <= '0;
            bcast_cnt_q  <= '0;
        end else begin
            for (int i = 0; i < N_FU; i++) begin
                count_q[i] <= count_d[i];
                head_q[i]  <= head_d[i];
                tail_q[i]  <= tail_d[i];
            end
            rr_q         <= rr_d;
            cdb_rs_num_q <= cdb_rs_num_d;
            cdb_data_q   <= cdb_data_d;
            bcast_cnt_q  <= bcast_cnt_d;
        end
    end

    // Storage needs no reset: validity is tracked by count/head/tail.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_FU; i++) begin
            if (push[i]) begin
                mem_q[i][tail_q[i]] <= '{tag: fu_tag[8*i +: 8], data: fu_data[32*i +: 32]};
            end
        end
    end

    assign cdb_rs_num = cdb_rs_num_q;
    assign cdb_data   = cdb_data_q;
    assign bcast_cnt  = bcast_cnt_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter (N_FU=4, DEPTH=2): reset, single result, contention,
// back-pressure, tag zero, mid-flight reset and broadcast counter wrap.
module tb_cdb_arbiter;

    logic         clk;
    logic         rst;
    logic [3:0]   fu_valid;
    logic [31:0]  fu_tag;
    logic [127:0] fu_data;
    logic [3:0]   fu_ready;
    logic [7:0]   cdb_rs_num;
    logic [31:0]  cdb_data;
    logic         pending;
    logic [15:0]  bcast_cnt;

    int n_cmp = 0;
    int n_err = 0;

    cdb_arbiter #(.N_FU(4), .DEPTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .fu_valid   (fu_valid),
        .fu_tag     (fu_tag),
        .fu_data    (fu_data),
        .fu_ready   (fu_ready),
        .cdb_rs_num (cdb_rs_num),
        .cdb_data   (cdb_data),
        .pending    (pending),
        .bcast_cnt  (bcast_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        fu_valid = '0;
        fu_tag   = '0;
        fu_data  = '0;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        fu_valid = '0;
        fu_tag   = '0;
        fu_data  = '0;
        step();
        step();
        n_cmp++; if (cdb_rs_num !== 8'h00) begin n_err++; $display("FAIL reset_tag got %h exp 00", cdb_rs_num); end
        n_cmp++; if (cdb_data !== 32'h0) begin n_err++; $display("FAIL reset_data got %h exp 0", cdb_data); end
        n_cmp++; if (pending !== 1'b0) begin n_err++; $display("FAIL reset_pending got %b exp 0", pending); end
        n_cmp++; if (bcast_cnt !== 16'h0) begin n_err++; $display("FAIL reset_cnt got %h exp 0", bcast_cnt); end
        n_cmp++; if (fu_ready !== 4'h0) begin n_err++; $display("FAIL reset_ready_in_rst got %h exp 0", fu_ready); end
        rst = 1'b0;
        #1;
        n_cmp++; if (fu_ready !== 4'hF) begin n_err++; $display("FAIL reset_ready_after got %h exp F", fu_ready); end
    endtask

    task automatic test_single();
        do_reset();
        fu_valid       = 4'b0010;
        fu_tag[15:8]   = 8'h21;
        fu_data[63:32] = 32'hDEADBEEF;
        step();
        fu_valid = '0;
        n_cmp++; if (cdb_rs_num !== 8'h00) begin n_err++; $display("FAIL single_edge0_tag got %h exp 00", cdb_rs_num); end
        n_cmp++; if (pending !== 1'b1) begin n_err++; $display("FAIL single_pending got %b exp 1", pending); end
        step();
        n_cmp++; if (cdb_rs_num !== 8'h21) begin n_err++; $display("FAIL single_tag got %h exp 21", cdb_rs_num); end
        n_cmp++; if (cdb_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_data got %h exp DEADBEEF", cdb_data); end
        n_cmp++; if (bcast_cnt !== 16'd1) begin n_err++; $display("FAIL single_cnt got %0d exp 1", bcast_cnt); end
        n_cmp++; if (pending !== 1'b0) begin n_err++; $display("FAIL single_pending_drain got %b exp 0", pending); end
        step();
        n_cmp++; if (cdb_rs_num !== 8'h00) begin n_err++; $display("FAIL single_after_tag got %h exp 00", cdb_rs_num); end
        n_cmp++; if (cdb_data !== 32'h0) begin n_err++; $display("FAIL single_after_data got %h exp 0", cdb_data); end
        n_cmp++; if (bcast_cnt !== 16'd1) begin n_err++; $display("FAIL single_after_cnt got %0d exp 1", bcast_cnt); end
    endtask

    task automatic test_contention();
        logic [7:0] exp_tags [0:4];
        exp_tags = '{8'h01, 8'h21, 8'h41, 8'h61, 8'h00};
        do_reset();
        fu_valid = 4'b1111;
        fu_tag   = {8'h61, 8'h41, 8'h21, 8'h01};
        fu_data  = {32'h3333_0061, 32'h2222_0041, 32'h1111_0021, 32'h0000_0001};
        step();
        fu_valid = '0;
        n_cmp++; if (cdb_rs_num !== 8'h00) begin n_err++; $display("FAIL cont_edge0 got %h exp 00", cdb_rs_num); end
        for (int k = 0; k < 5; k++) begin
            step();
            n_cmp++;
            if (cdb_rs_num !== exp_tags[k]) begin
                n_err++; $display("FAIL cont_tag[%0d] got %h exp %h", k, cdb_rs_num, exp_tags[k]);
            end
        end
        n_cmp++; if (bcast_cnt !== 16'd4) begin n_err++; $display("FAIL cont_cnt got %0d exp 4", bcast_cnt); end
        // rr pointer should now be back at FU0: FU0 wins over FU3.
        fu_valid = 4'b1001;
        fu_tag   = {8'h62, 8'h00, 8'h00, 8'h02};
        step();
        fu_valid = '0;
        step();
        n_cmp++; if (cdb_rs_num !== 8'h02) begin n_err++; $display("FAIL cont_rr_first got %h exp 02", cdb_rs_num); end
        step();
        n_cmp++; if (cdb_rs_num !== 8'h62) begin n_err++; $display("FAIL cont_rr_second got %h exp 62", cdb_rs_num); end
    endtask

    task automatic test_back_pressure();
        logic [7:0] t0 [0:5];
        logic [7:0] t2 [0:5];
        logic [7:0] exp_cdb [0:9];
        logic       exp_r0 [0:5];
        logic       exp_r2 [0:5];
        logic [31:0] exp_d;
        t0      = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h04, 8'h05};
        t2      = '{8'h41, 8'h42, 8'h43, 8'h43, 8'h44, 8'h44};
        exp_cdb = '{8'h00, 8'h01, 8'h41, 8'h02, 8'h42, 8'h03, 8'h43, 8'h04, 8'h44, 8'h00};
        exp_r0  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_r2  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        do_reset();
        for (int e = 0; e < 10; e++) begin
            if (e < 6) begin
                fu_valid         = 4'b0101;
                fu_tag[7:0]      = t0[e];
                fu_tag[23:16]    = t2[e];
                fu_data[31:0]    = {24'hC0FFEE, t0[e]};
                fu_data[95:64]   = {24'hC0FFEE, t2[e]};
            end else begin
                fu_valid = '0;
            end
            step();
            exp_d = (exp_cdb[e] == 8'h00) ? 32'h0 : {24'hC0FFEE, exp_cdb[e]};
            n_cmp++;
            if (cdb_rs_num !== exp_cdb[e]) begin
                n_err++; $display("FAIL bp_tag[%0d] got %h exp %h", e, cdb_rs_num, exp_cdb[e]);
            end
            n_cmp++;
            if (cdb_data !== exp_d) begin
                n_err++; $display("FAIL bp_data[%0d] got %h exp %h", e, cdb_data, exp_d);
            end
            if (e < 6) begin
                n_cmp++;
                if (fu_ready[0] !== exp_r0[e]) begin
                    n_err++; $display("FAIL bp_ready0[%0d] got %b exp %b", e, fu_ready[0], exp_r0[e]);
                end
                n_cmp++;
                if (fu_ready[2] !== exp_r2[e]) begin
                    n_err++; $display("FAIL bp_ready2[%0d] got %b exp %b", e, fu_ready[2], exp_r2[e]);
                end
            end
        end
        n_cmp++; if (bcast_cnt !== 16'd8) begin n_err++; $display("FAIL bp_cnt got %0d exp 8", bcast_cnt); end
        n_cmp++; if (pending !== 1'b0) begin n_err++; $display("FAIL bp_pending got %b exp 0", pending); end
    endtask

    task automatic test_tag_zero();
        do_reset();
        fu_valid       = 4'b1000;
        fu_tag[31:24]  = 8'h00;
        fu_data[127:96] = 32'h1234_5678;
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++; if (pending !== 1'b0) begin n_err++; $display("FAIL tz_pending[%0d] got %b exp 0", k, pending); end
            n_cmp++; if (cdb_rs_num !== 8'h00) begin n_err++; $display("FAIL tz_tag[%0d] got %h exp 00", k, cdb_rs_num); end
            n_cmp++; if (fu_ready[3] !== 1'b1) begin n_err++; $display("FAIL tz_ready[%0d] got %b exp 1", k, fu_ready[3]); end
        end
        fu_valid = '0;
        n_cmp++; if (bcast_cnt !== 16'd0) begin n_err++; $display("FAIL tz_cnt got %0d exp 0", bcast_cnt); end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        fu_valid      = 4'b1000;
        fu_tag[31:24] = 8'h61;
        step();
        fu_valid = 4'b0111;
        fu_tag   = {8'h00, 8'h41, 8'h21, 8'h01};
        step();
        n_cmp++; if (cdb_rs_num !== 8'h61) begin n_err++; $display("FAIL mid_pre_tag got %h exp 61", cdb_rs_num); end
        n_cmp++; if (bcast_cnt !== 16'd1) begin n_err++; $display("FAIL mid_pre_cnt got %0d exp 1", bcast_cnt); end
        rst      = 1'b1;
        fu_valid = 4'b0001;
        fu_tag   = {8'h00, 8'h00, 8'h00, 8'h05};
        #1;
        n_cmp++; if (fu_ready !== 4'h0) begin n_err++; $display("FAIL mid_ready_in_rst got %h exp 0", fu_ready); end
        step();
        n_cmp++; if (cdb_rs_num !== 8'h00) begin n_err++; $display("FAIL mid_rst_tag got %h exp 00", cdb_rs_num); end
        n_cmp++; if (pending !== 1'b0) begin n_err++; $display("FAIL mid_rst_pending got %b exp 0", pending); end
        n_cmp++; if (bcast_cnt !== 16'd0) begin n_err++; $display("FAIL mid_rst_cnt got %0d exp 0", bcast_cnt); end
        rst      = 1'b0;
        fu_valid = '0;
        #1;
        n_cmp++; if (fu_ready !== 4'hF) begin n_err++; $display("FAIL mid_ready_after got %h exp F", fu_ready); end
        for (int k = 0; k < 4; k++) begin
            step();
            n_cmp++; if (cdb_rs_num !== 8'h00) begin n_err++; $display("FAIL mid_stale[%0d] got %h exp 00", k, cdb_rs_num); end
        end
        n_cmp++; if (pending !== 1'b0) begin n_err++; $display("FAIL mid_pending_after got %b exp 0", pending); end
    endtask

    task automatic test_counter_wrap();
        do_reset();
        fu_valid      = 4'b0001;
        fu_tag[7:0]   = 8'h01;
        fu_data[31:0] = 32'hCAFE_0001;
        for (int k = 0; k < 65535; k++) step();
        n_cmp++; if (bcast_cnt !== 16'hFFFE) begin n_err++; $display("FAIL wrap_fffe got %h exp FFFE", bcast_cnt); end
        step();
        fu_valid = '0;
        n_cmp++; if (bcast_cnt !== 16'hFFFF) begin n_err++; $display("FAIL wrap_ffff got %h exp FFFF", bcast_cnt); end
        n_cmp++; if (cdb_rs_num !== 8'h01) begin n_err++; $display("FAIL wrap_tag got %h exp 01", cdb_rs_num); end
        step();
        n_cmp++; if (bcast_cnt !== 16'h0000) begin n_err++; $display("FAIL wrap_zero got %h exp 0000", bcast_cnt); end
        step();
        n_cmp++; if (bcast_cnt !== 16'h0000) begin n_err++; $display("FAIL wrap_hold got %h exp 0000", bcast_cnt); end
        n_cmp++; if (cdb_rs_num !== 8'h00) begin n_err++; $display("FAIL wrap_idle_tag got %h exp 00", cdb_rs_num); end
    endtask

    initial begin
        rst      = 1'b1;
        fu_valid = '0;
        fu_tag   = '0;
        fu_data  = '0;
        test_reset();
        test_single();
        test_contention();
        test_back_pressure();
        test_tag_zero();
        test_reset_midflight();
        test_counter_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
